slave_out: RTL

- Slave-side read-data transmitter. Sits directly upstream of the master receive stage.
- On a read request it fetches bytes from the slave's local memory and serializes each one MSB-first onto the single-bit bus line.
- It qualifies each byte with slave_valid, waits for master_ready, and pulses tx_done when the whole single or burst read has been sent.

---
 rtl/bus_pkg.sv | 20 ++
 rtl/slave_out_if.sv | 32 +++
 rtl/slave_out_piso_shift.sv | 36 +++
 rtl/slave_out.sv | 78 +++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the slave/master serial bus: default widths,
// instruction encodings and the slave transmitter state encoding.
package bus_pkg;

   localparam int ADDR_WIDTH_DEF = 12;
   localparam int DATA_WIDTH_DEF = 8;

   // Instruction field seen by the slave decoder.
   localparam logic [1:0] INSTR_READ = 2'b11;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_FETCH = 3'd1;
   localparam state_t ST_LOAD  = 3'd2;
   localparam state_t ST_OFFER = 3'd3;
   localparam state_t ST_SHIFT = 3'd4;
   localparam state_t ST_DONE  = 3'd5;

endpackage

// File: rtl/slave_out_if.sv
// Bus bundle between the slave read-data transmitter, its local memory,
// the slave decoder and the master receive stage.
interface slave_out_if
   import bus_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

   logic                  read_en;
   logic [ADDR_WIDTH-1:0] start_addr;
   logic [ADDR_WIDTH-1:0] burst_num;
   logic                  master_ready;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_rd_en;
   logic [DATA_WIDTH-1:0] mem_data;
   logic                  slave_valid;
   logic                  tx_data;
   logic                  tx_done;
   logic                  busy;

   modport slave (
      input  read_en, start_addr, burst_num, master_ready, mem_data,
      output mem_addr, mem_rd_en, slave_valid, tx_data, tx_done, busy
   );

   modport master (
      output read_en, start_addr, burst_num, master_ready, mem_data,
      input  mem_addr, mem_rd_en, slave_valid, tx_data, tx_done, busy
   );

endinterface

// File: rtl/slave_out_piso_shift.sv
// Parallel-in serial-out shifter: loads one word, emits it MSB first and
// flags the cycle carrying the final bit.
module piso_shift #(
   parameter int  DATA_WIDTH = 8,
   localparam int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  shift_en,
   input  logic [DATA_WIDTH-1:0] par_in,
   output logic                  serial_out,
   output logic                  last_bit
);

   logic [DATA_WIDTH-1:0] shift_reg;
   logic [CNT_WIDTH-1:0]  bit_cnt;

   // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else if (load) begin
         shift_reg <= par_in;
         bit_cnt   <= '0;
      end else if (shift_en) begin
         shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
         bit_cnt   <= bit_cnt + 1'b1;
      end
   end

   assign serial_out = shift_reg[DATA_WIDTH-1];
   assign last_bit   = shift_en && (bit_cnt == CNT_WIDTH'(DATA_WIDTH - 1));

endmodule

// File: rtl/slave_out.sv
// Slave-side read-data transmitter: fetches words from local memory and
// serializes them MSB first, one word per master_ready handshake.
module slave_out
   import bus_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input logic       clk,
   input logic       reset,
   slave_out_if.slave bus
);

   localparam logic [ADDR_WIDTH:0] WORDS_ONE = (ADDR_WIDTH + 1)'(1);

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] addr;
   logic [ADDR_WIDTH:0]   words;
   logic                  serial_bit;
   logic                  last_bit;
   logic                  more_words;

   assign more_words = (words > WORDS_ONE);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (bus.read_en) state_nxt = ST_FETCH;
         ST_FETCH: state_nxt = ST_LOAD;
         ST_LOAD:  state_nxt = ST_OFFER;
         ST_OFFER: if (bus.master_ready) state_nxt = ST_SHIFT;
         ST_SHIFT: if (last_bit) state_nxt = more_words ? ST_FETCH : ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         addr  <= '0;
         words <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && bus.read_en) begin
            addr  <= bus.start_addr;
            // A zero burst count still moves one word.
            words <= (bus.burst_num == '0) ? WORDS_ONE : {1'b0, bus.burst_num};
         end else if (state == ST_SHIFT && last_bit && more_words) begin
            addr  <= addr + 1'b1;
            words <= words - WORDS_ONE;
         end
      end
   end

   piso_shift #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_piso (
      .clk        (clk),
      .reset      (reset),
      .load       (state == ST_LOAD),
      .shift_en   (state == ST_SHIFT),
      .par_in     (bus.mem_data),
      .serial_out (serial_bit),
      .last_bit   (last_bit)
   );

   // The line idles low whenever no word is being offered or shifted.
   assign bus.slave_valid = (state == ST_OFFER) || (state == ST_SHIFT);
   assign bus.tx_data     = bus.slave_valid && serial_bit;
   assign bus.tx_done     = (state == ST_DONE);
   assign bus.busy        = (state != ST_IDLE);
   assign bus.mem_rd_en   = (state == ST_FETCH);
   assign bus.mem_addr    = addr;

endmodule
